fpro_bus_arbiter: RTL and testbench
===================================

FPRO_BUS_ARBITER -- requirements
Module: fpro_bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, FPro data width.
REQ-002 SHALL have parameter FIRST_GNT, default 0, index of the master favoured first after reset.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port m0_req / m1_req  input  1 each  level request; held high until the matching ack.
REQ-006 SHALL have port m0_wr / m1_wr  input  1 each  1 = write, 0 = read; valid while req is high.
REQ-007 SHALL have port m0_addr / m1_addr  input  22 each  bit 21 = video select, bits 20:0 = FPro word address.
REQ-008 SHALL have port m0_wr_data / m1_wr_data  input  DATA_W each  write data.
REQ-009 SHALL have port m0_ack / m1_ack  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have port m0_rd_data / m1_rd_data  output  DATA_W each  registered read data.
REQ-011 SHALL have port fp_video_cs, fp_mmio_cs, fp_wr, fp_rd  output  1 each  FPro bus strobes.
REQ-012 SHALL have port fp_addr  output  21  FPro word address.
REQ-013 SHALL have port fp_wr_data  output  DATA_W  FPro write data.
REQ-014 SHALL have port fp_rd_data  input  DATA_W  FPro read data, valid combinationally in the strobe cycle.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ISSUE, DONE.
REQ-017 IDLE: if any req is high, SHALL grant one master, latch its wr, addr and wr_data into a command register, record the grant index, and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: when both req are high, the master not granted last wins; a single requester always wins.
REQ-019 ISSUE (exactly one cycle): SHALL drive fp_wr = cmd_wr and fp_rd = !cmd_wr.
REQ-020 ISSUE: SHALL drive fp_video_cs = cmd_addr[21], fp_mmio_cs = !cmd_addr[21], fp_addr = cmd_addr[20:0] and fp_wr_data = cmd wr_data.
REQ-021 ISSUE: on a read, SHALL capture fp_rd_data into the granted master's rd_data register at the cycle end; then go to DONE.
REQ-022 Outside ISSUE, all fp_* outputs SHALL be 0.
REQ-023 DONE (one cycle): SHALL pulse the granted master's ack high and return to IDLE; req inputs SHALL be ignored in DONE.
REQ-024 Latency SHALL be fixed: req sampled in IDLE at cycle N -> bus strobe at N+1 -> ack at N+2; throughput is at most one transaction per 3 cycles.
REQ-025 A master's rd_data register SHALL hold its value until that master's next read completes; writes SHALL not alter it.
REQ-026 Once a command is latched, it SHALL complete and ack even if req drops; a req dropped before being sampled in IDLE SHALL produce no bus activity.
REQ-027 Req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-028 At most one of m0_ack and m1_ack, and at most one of fp_wr and fp_rd, SHALL be high in any cycle.

Reset
REQ-029 While reset_n = 0 at a clock edge: state -> IDLE; all fp_*, acks and busy -> 0; both rd_data -> 0; last-grant register -> 1 - FIRST_GNT.
REQ-030 Reset asserted during ISSUE or DONE SHALL abort the transaction: no ack issued, strobes low from the next cycle.

Verification
REQ-031 Reset, then m0 read with addr 0x000010 (fp_rd_data = 0xDEADBEEF) -> fp_mmio_cs = 1, fp_rd = 1, fp_addr = 0x10 at cycle 1; m0_ack at cycle 2; m0_rd_data = 0xDEADBEEF.
REQ-032 m1 write with addr 0x200005, data 0x12345678 -> fp_video_cs = 1, fp_wr = 1, fp_addr = 0x000005, fp_wr_data = 0x12345678 for one cycle; m1_ack next cycle; m1_rd_data unchanged.
REQ-033 Both req held high continuously after reset with FIRST_GNT = 0 -> grants alternate m0, m1, m0, m1; one ack every 3 cycles.
REQ-034 m0 req pulsed for one cycle, sampled in IDLE, then dropped -> transaction still issued and m0_ack still pulses.
REQ-035 reset_n low during ISSUE -> no ack; fp_* = 0, busy = 0 and rd_data = 0 on the following cycle.
REQ-036 Req held high through ack -> second identical transaction issued starting in the IDLE cycle after ack.

Source files
------------

// File: rtl/fpro_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single FPro bus.
// Each transaction is IDLE -> ISSUE (one strobe cycle) -> DONE (ack pulse).
module fpro_bus_arbiter #(
   parameter int DATA_W    = 32,
   parameter int FIRST_GNT = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [21:0]       m0_addr,
   input  logic [DATA_W-1:0] m0_wr_data,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rd_data,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [21:0]       m1_addr,
   input  logic [DATA_W-1:0] m1_wr_data,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rd_data,
   output logic              fp_video_cs,
   output logic              fp_mmio_cs,
   output logic              fp_wr,
   output logic              fp_rd,
   output logic [20:0]       fp_addr,
   output logic [DATA_W-1:0] fp_wr_data,
   input  logic [DATA_W-1:0] fp_rd_data,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic LAST_GNT_RST = (FIRST_GNT == 32'sd0) ? 1'b1 : 1'b0;

   state_t              state;
   state_t              state_nxt;
   logic                any_req;
   logic                sel;
   logic                sel_wr;
   logic [21:0]         sel_addr;
   logic [DATA_W-1:0]   sel_wr_data;
   logic                gnt;
   logic                last_gnt;

   logic                fp_video_cs_nxt;
   logic                fp_mmio_cs_nxt;
   logic                fp_wr_nxt;
   logic                fp_rd_nxt;
   logic [20:0]         fp_addr_nxt;
   logic [DATA_W-1:0]   fp_wr_data_nxt;
   logic                m0_ack_nxt;
   logic                m1_ack_nxt;
   logic                busy_nxt;

   // Round-robin pick: on contention the master not granted last wins.
   always_comb begin
      any_req = m0_req | m1_req;
      if (m0_req && m1_req) begin
         sel = ~last_gnt;
      end else if (m1_req) begin
         sel = 1'b1;
      end else begin
         sel = 1'b0;
      end
      if (sel) begin
         sel_wr      = m1_wr;
         sel_addr    = m1_addr;
         sel_wr_data = m1_wr_data;
      end else begin
         sel_wr      = m0_wr;
         sel_addr    = m0_addr;
         sel_wr_data = m0_wr_data;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; requests are only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs, keyed on the state being entered.
   always_comb begin
      fp_video_cs_nxt = 1'b0;
      fp_mmio_cs_nxt  = 1'b0;
      fp_wr_nxt       = 1'b0;
      fp_rd_nxt       = 1'b0;
      fp_addr_nxt     = 21'd0;
      fp_wr_data_nxt  = {DATA_W{1'b0}};
      m0_ack_nxt      = 1'b0;
      m1_ack_nxt      = 1'b0;
      busy_nxt        = (state_nxt != IDLE);
      case (state_nxt)
         ISSUE: begin
            fp_wr_nxt       = sel_wr;
            fp_rd_nxt       = ~sel_wr;
            fp_video_cs_nxt = sel_addr[21];
            fp_mmio_cs_nxt  = ~sel_addr[21];
            fp_addr_nxt     = sel_addr[20:0];
            fp_wr_data_nxt  = sel_wr_data;
         end
         DONE: begin
            m0_ack_nxt = ~gnt;
            m1_ack_nxt = gnt;
         end
         default: begin
            busy_nxt = (state_nxt != IDLE);
         end
      endcase
   end

   // Output registers; during ISSUE the strobe registers hold the latched command.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fp_video_cs <= 1'b0;
         fp_mmio_cs  <= 1'b0;
         fp_wr       <= 1'b0;
         fp_rd       <= 1'b0;
         fp_addr     <= 21'd0;
         fp_wr_data  <= {DATA_W{1'b0}};
         m0_ack      <= 1'b0;
         m1_ack      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         fp_video_cs <= fp_video_cs_nxt;
         fp_mmio_cs  <= fp_mmio_cs_nxt;
         fp_wr       <= fp_wr_nxt;
         fp_rd       <= fp_rd_nxt;
         fp_addr     <= fp_addr_nxt;
         fp_wr_data  <= fp_wr_data_nxt;
         m0_ack      <= m0_ack_nxt;
         m1_ack      <= m1_ack_nxt;
         busy        <= busy_nxt;
      end
   end

   // Grant index of the command in flight and round-robin history.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         gnt      <= 1'b0;
         last_gnt <= LAST_GNT_RST;
      end else if (state == IDLE && any_req) begin
         gnt      <= sel;
         last_gnt <= sel;
      end
   end

   // Read data lands in the granted master's register at the end of the strobe cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         m0_rd_data <= {DATA_W{1'b0}};
         m1_rd_data <= {DATA_W{1'b0}};
      end else if (state == ISSUE && fp_rd) begin
         if (gnt) begin
            m1_rd_data <= fp_rd_data;
         end else begin
            m0_rd_data <= fp_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Directed bench for fpro_bus_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_fpro_bus_arbiter;

   logic        clk;
   logic        reset_n;
   logic        m0_req, m1_req, m0_wr, m1_wr;
   logic [21:0] m0_addr, m1_addr;
   logic [31:0] m0_wr_data, m1_wr_data;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic        fp_video_cs, fp_mmio_cs, fp_wr, fp_rd;
   logic [20:0] fp_addr;
   logic [31:0] fp_wr_data, fp_rd_data;
   logic        busy;

   int total;
   int bad;

   fpro_bus_arbiter #(.DATA_W(32), .FIRST_GNT(0)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
      .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
      .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
      .fp_video_cs(fp_video_cs), .fp_mmio_cs(fp_mmio_cs), .fp_wr(fp_wr), .fp_rd(fp_rd),
      .fp_addr(fp_addr), .fp_wr_data(fp_wr_data), .fp_rd_data(fp_rd_data),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      reset_n = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
      m0_addr = 22'd0; m1_addr = 22'd0; m0_wr_data = 32'd0; m1_wr_data = 32'd0;
      fp_rd_data = 32'd0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if ({busy, m0_ack, m1_ack} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b want=000", {busy, m0_ack, m1_ack}); end
      total++; if ({fp_video_cs, fp_mmio_cs, fp_wr, fp_rd} !== 4'b0000) begin bad++; $display("FAIL reset_strobes got=%b want=0000", {fp_video_cs, fp_mmio_cs, fp_wr, fp_rd}); end
      total++; if ({fp_addr, fp_wr_data} !== 53'd0) begin bad++; $display("FAIL reset_bus got=%h want=0", {fp_addr, fp_wr_data}); end
      total++; if ({m0_rd_data, m1_rd_data} !== 64'd0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", {m0_rd_data, m1_rd_data}); end
   endtask

   task automatic test_read();
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 22'h000010; fp_rd_data = 32'hDEADBEEF;
      @(negedge clk);
      total++; if ({fp_mmio_cs, fp_video_cs, fp_rd, fp_wr} !== 4'b1010) begin bad++; $display("FAIL read_strobes got=%b want=1010", {fp_mmio_cs, fp_video_cs, fp_rd, fp_wr}); end
      total++; if (fp_addr !== 21'h10) begin bad++; $display("FAIL read_addr got=%h want=10", fp_addr); end
      total++; if ({busy, m0_ack} !== 2'b10) begin bad++; $display("FAIL read_busy_noack got=%b want=10", {busy, m0_ack}); end
      @(negedge clk);
      total++; if ({m0_ack, m1_ack, fp_rd, busy} !== 4'b1001) begin bad++; $display("FAIL read_ack got=%b want=1001", {m0_ack, m1_ack, fp_rd, busy}); end
      total++; if (m0_rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h want=deadbeef", m0_rd_data); end
      m0_req = 1'b0; fp_rd_data = 32'h0;
      @(negedge clk);
      total++; if ({m0_ack, busy} !== 2'b00) begin bad++; $display("FAIL read_idle got=%b want=00", {m0_ack, busy}); end
   endtask

   task automatic test_write();
      m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 22'h200005; m1_wr_data = 32'h12345678;
      fp_rd_data = 32'hBADBAD00;
      @(negedge clk);
      total++; if ({fp_video_cs, fp_mmio_cs, fp_wr, fp_rd} !== 4'b1010) begin bad++; $display("FAIL write_strobes got=%b want=1010", {fp_video_cs, fp_mmio_cs, fp_wr, fp_rd}); end
      total++; if (fp_addr !== 21'h000005) begin bad++; $display("FAIL write_addr got=%h want=5", fp_addr); end
      total++; if (fp_wr_data !== 32'h12345678) begin bad++; $display("FAIL write_data got=%h want=12345678", fp_wr_data); end
      @(negedge clk);
      total++; if ({m1_ack, m0_ack, fp_wr, fp_video_cs} !== 4'b1000) begin bad++; $display("FAIL write_ack got=%b want=1000", {m1_ack, m0_ack, fp_wr, fp_video_cs}); end
      m1_req = 1'b0; m1_wr = 1'b0;
      @(negedge clk);
      total++; if (m1_rd_data !== 32'd0) begin bad++; $display("FAIL write_m1_rd_kept got=%h want=0", m1_rd_data); end
      total++; if (m0_rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL write_m0_rd_kept got=%h want=deadbeef", m0_rd_data); end
   endtask

   task automatic test_round_robin();
      logic exp0, exp1;
      do_reset();
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 22'h000001;
      m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 22'h000002;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         exp0 = ((c % 6) == 2);
         exp1 = ((c % 6) == 5);
         total++; if ({m0_ack, m1_ack} !== {exp0, exp1}) begin bad++; $display("FAIL rr_ack c=%0d got=%b want=%b", c, {m0_ack, m1_ack}, {exp0, exp1}); end
         if ((c % 3) == 1) begin
            total++; if ({fp_wr, fp_addr} !== {1'b1, ((c % 6) == 1) ? 21'd1 : 21'd2}) begin bad++; $display("FAIL rr_grant c=%0d got=%b/%h", c, fp_wr, fp_addr); end
         end
         if (c == 12) begin
            m0_req = 1'b0; m1_req = 1'b0;
         end
      end
   endtask

   task automatic test_req_pulse();
      @(negedge clk);
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 22'h000003; fp_rd_data = 32'hA5A50001;
      @(negedge clk);
      m0_req = 1'b0;
      total++; if ({fp_rd, fp_addr} !== {1'b1, 21'd3}) begin bad++; $display("FAIL pulse_issue got=%b/%h want=1/3", fp_rd, fp_addr); end
      @(negedge clk);
      total++; if (m0_ack !== 1'b1) begin bad++; $display("FAIL pulse_ack got=%b want=1", m0_ack); end
      @(negedge clk);
      total++; if (m0_rd_data !== 32'hA5A50001) begin bad++; $display("FAIL pulse_data got=%h want=a5a50001", m0_rd_data); end
      m1_req = 1'b1;
      #2 m1_req = 1'b0;
      @(negedge clk);
      total++; if ({busy, fp_wr, fp_rd, fp_mmio_cs} !== 4'b0000) begin bad++; $display("FAIL unsampled_req got=%b want=0000", {busy, fp_wr, fp_rd, fp_mmio_cs}); end
   endtask

   task automatic test_reset_abort();
      m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 22'h000007; fp_rd_data = 32'h77777777;
      @(negedge clk);
      total++; if ({fp_rd, busy} !== 2'b11) begin bad++; $display("FAIL abort_pre got=%b want=11", {fp_rd, busy}); end
      reset_n = 1'b0;
      @(negedge clk);
      m1_req = 1'b0; reset_n = 1'b1;
      total++; if ({m0_ack, m1_ack, busy} !== 3'b000) begin bad++; $display("FAIL abort_ack got=%b want=000", {m0_ack, m1_ack, busy}); end
      total++; if ({fp_video_cs, fp_mmio_cs, fp_wr, fp_rd} !== 4'b0000) begin bad++; $display("FAIL abort_strobes got=%b want=0000", {fp_video_cs, fp_mmio_cs, fp_wr, fp_rd}); end
      total++; if ({m0_rd_data, m1_rd_data} !== 64'd0) begin bad++; $display("FAIL abort_rd_data got=%h want=0", {m0_rd_data, m1_rd_data}); end
      @(negedge clk);
      total++; if ({m0_ack, m1_ack, busy} !== 3'b000) begin bad++; $display("FAIL abort_after got=%b want=000", {m0_ack, m1_ack, busy}); end
   endtask

   task automatic test_back_to_back();
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 22'h20ABCD; m0_wr_data = 32'hCAFEF00D;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1 || c == 4) begin
            total++; if ({fp_wr, fp_video_cs, fp_addr, fp_wr_data} !== {2'b11, 21'h0ABCD, 32'hCAFEF00D}) begin bad++; $display("FAIL b2b_issue c=%0d got=%b%b/%h/%h", c, fp_wr, fp_video_cs, fp_addr, fp_wr_data); end
         end else if (c == 2 || c == 5) begin
            total++; if ({m0_ack, fp_wr} !== 2'b10) begin bad++; $display("FAIL b2b_ack c=%0d got=%b want=10", c, {m0_ack, fp_wr}); end
         end else begin
            total++; if ({busy, fp_wr, m0_ack} !== 3'b000) begin bad++; $display("FAIL b2b_idle c=%0d got=%b want=000", c, {busy, fp_wr, m0_ack}); end
         end
      end
      m0_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if ({busy, fp_wr} !== 2'b00) begin bad++; $display("FAIL b2b_end got=%b want=00", {busy, fp_wr}); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_read();
      test_write();
      test_round_robin();
      test_req_pulse();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
